// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one serial transmitter between
// NUM_REQ packet sources. It captures the winner's flit, drives the
// TX_Data/TX_Data_Valid handshake, follows TX_Ready through acceptance and
// completion, then pulses Ack for the winner.
// Optional feature: define TX_ARB_WATCHDOG_EN to abort a transfer that stays
// in SEND/WAIT_DONE for WD_LIMIT cycles (Tx_Err pulse, no Ack).
module tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 55,
    parameter int WD_LIMIT = 255
) (
    input  logic                       Clk_S,
    input  logic                       Rst_n,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*DATA_W-1:0]  Req_Data,
    output logic [NUM_REQ-1:0]         Ack,
    output logic [DATA_W-1:0]          TX_Data,
    output logic                       TX_Data_Valid,
    input  logic                       TX_Ready,
    output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
    output logic                       Busy,
    output logic                       Tx_Err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    w_grant_nxt;
    logic [DATA_W-1:0]   r_tx_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_tx_valid;
    logic                w_valid_nxt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_nxt;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_win_data;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0]     r_wd_cnt;
    logic [WD_W-1:0]     w_wd_nxt;
    logic                r_tx_err;
    logic                w_err_nxt;
`endif

    // Round-robin search: first requester after the last winner, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && Req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        w_win_data = Req_Data[int'(w_winner)*DATA_W +: DATA_W];
    end

    // Next-state and registered-output values for the transfer FSM
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_ack_nxt   = '0;
`ifdef TX_ARB_WATCHDOG_EN
        w_err_nxt   = 1'b0;
        w_wd_nxt    = r_wd_cnt + 1'b1;
`endif
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                // No arbitration while Ack is still being presented
                if (TX_Ready && w_found && (r_ack == '0)) begin
                    w_data_nxt  = w_win_data;
                    w_grant_nxt = w_winner;
                    w_rr_nxt    = w_winner;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // TX_Ready lags the transmitter, so only a sampled 0 means accepted
                if (!TX_Ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (TX_Ready) begin
                    w_ack_nxt[r_grant] = 1'b1;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef TX_ARB_WATCHDOG_EN
        if (w_state_nxt != r_state) begin
            w_wd_nxt = '0;
        end
        // Abort a transfer that has not progressed; rr_ptr keeps the winner
        if ((r_state != S_IDLE) && (w_state_nxt == r_state) &&
            (r_wd_cnt == WD_W'(WD_LIMIT - 1))) begin
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b1;
            w_wd_nxt    = '0;
            w_state_nxt = S_IDLE;
        end
`endif
    end

    // State, round-robin pointer and transmitter handshake registers
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_grant    <= w_grant_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

`ifdef TX_ARB_WATCHDOG_EN
    // Watchdog cycle counter and abort pulse
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wd_cnt <= '0;
            r_tx_err <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_nxt;
            r_tx_err <= w_err_nxt;
        end
    end

    assign Tx_Err = r_tx_err;
`else
    assign Tx_Err = 1'b0;
`endif

    assign Ack           = r_ack;
    assign TX_Data       = r_tx_data;
    assign TX_Data_Valid = r_tx_valid;
    assign Grant_Id      = r_grant;
    assign Busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized requesters and transmitter model; a reference
// round-robin model predicts each grant and pushes it to a scoreboard queue
// that a separate monitor drains whenever the DUT starts or acks a transfer.
module tb_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 55;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                       Clk_S = 1'b0;
    logic                       Rst_n;
    logic [NUM_REQ-1:0]         Req;
    logic [NUM_REQ*DATA_W-1:0]  Req_Data;
    logic [NUM_REQ-1:0]         Ack;
    logic [DATA_W-1:0]          TX_Data;
    logic                       TX_Data_Valid;
    logic                       TX_Ready;
    logic [IDX_W-1:0]           Grant_Id;
    logic                       Busy;
    logic                       Tx_Err;

    tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .WD_LIMIT(255)
    ) dut (
        .Clk_S        (Clk_S),
        .Rst_n        (Rst_n),
        .Req          (Req),
        .Req_Data     (Req_Data),
        .Ack          (Ack),
        .TX_Data      (TX_Data),
        .TX_Data_Valid(TX_Data_Valid),
        .TX_Ready     (TX_Ready),
        .Grant_Id     (Grant_Id),
        .Busy         (Busy),
        .Tx_Err       (Tx_Err)
    );

    always #5 Clk_S = ~Clk_S;

    typedef struct {
        int                win;
        logic [DATA_W-1:0] data;
        int                vc;   // cycles Valid should stay high
        int                gap;  // cycles between Valid falling and Ack
    } exp_t;

    exp_t grant_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: which requesters are holding Req, their flits, last winner
    logic [NUM_REQ-1:0] m_pend;
    logic [DATA_W-1:0]  m_data [NUM_REQ];
    int                 m_rr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_S);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_flit();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // Rotation rule: scan upward from the position after the last winner
    function automatic int pick(input logic [NUM_REQ-1:0] p, input int rr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (p[IDX_W'((rr + k) % NUM_REQ)]) return (rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic drive_req();
        Req = m_pend;
        for (int i = 0; i < NUM_REQ; i++) Req_Data[i*DATA_W +: DATA_W] = m_data[i];
    endtask

    task automatic add_req(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_data[i] = rnd_flit();
            end
        end
    endtask

    // One full transfer. Entry: just after an edge, DUT idle and not acking.
    // d: cycles TX_Ready held low before arbitration, h: extra Ready-high
    // cycles after Valid, l: Ready-low cycles, drop: winner drops Req after grant.
    task automatic do_transfer(input int d, input int h, input int l, input bit drop);
        int   win;
        int   t;
        exp_t e;
        drive_req();
        TX_Ready = (d == 0);
        for (int i = 0; i < d; i++) tick();
        TX_Ready = 1'b1;
        win    = pick(m_pend, m_rr);
        e.win  = win;
        e.data = m_data[win];
        e.vc   = h + 1;
        e.gap  = l;
        grant_q.push_back(e);
        m_rr = win;
        tick();
        if (drop) begin
            m_pend[win] = 1'b0;
            m_data[win] = rnd_flit();
            drive_req();
        end
        for (int i = 0; i < h; i++) tick();
        TX_Ready = 1'b0;
        for (int i = 0; i < l; i++) tick();
        TX_Ready = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while ((Ack == '0) && (t < 8));
        chk("ack_within_budget", 64'(Ack != '0), 64'd1);
        m_pend[win] = 1'b0;
        drive_req();
        tick();
    endtask

    // Monitor: pops an expectation on each Valid rise, checks it through to Ack
    initial begin
        exp_t               cur;
        bit                 act;
        int                 vcnt;
        int                 gcnt;
        logic               pv;
        logic [NUM_REQ-1:0] pa;
        act  = 1'b0;
        vcnt = 0;
        gcnt = 0;
        pv   = 1'b0;
        pa   = '0;
        forever begin
            @(negedge Clk_S);
            if (!Rst_n) begin
                act = 1'b0;
                pv  = 1'b0;
                pa  = '0;
            end else begin
                if (TX_Data_Valid && !pv) begin
                    chk("no_grant_before_ack", 64'(act), 64'd0);
                    chk("grant_expected", 64'(grant_q.size() != 0), 64'd1);
                    if (grant_q.size() != 0) begin
                        cur  = grant_q.pop_front();
                        act  = 1'b1;
                        vcnt = 0;
                        gcnt = 0;
                        chk("grant_id", 64'(Grant_Id), 64'(cur.win));
                        chk("grant_data", 64'(TX_Data), 64'(cur.data));
                        chk("busy_at_grant", 64'(Busy), 64'd1);
                    end
                end
                if (Ack != '0) begin
                    chk("ack_single_cycle", 64'(pa), 64'd0);
                    chk("ack_expected", 64'(act), 64'd1);
                end
                if (act) begin
                    if (TX_Data_Valid) vcnt++;
                    else if (Ack == '0) gcnt++;
                    if (!TX_Data_Valid && pv) chk("valid_cycles", 64'(vcnt), 64'(cur.vc));
                    if (Ack != '0) begin
                        chk("ack_onehot", 64'(Ack), 64'd1 << cur.win);
                        chk("ack_latency", 64'(gcnt), 64'(cur.gap));
                        chk("data_held_to_ack", 64'(TX_Data), 64'(cur.data));
                        chk("grant_id_at_ack", 64'(Grant_Id), 64'(cur.win));
                        chk("valid_low_at_ack", 64'(TX_Data_Valid), 64'd0);
                        chk("idle_at_ack", 64'(Busy), 64'd0);
                        chk("no_tx_err", 64'(Tx_Err), 64'd0);
                        act = 1'b0;
                    end
                end
                pv = TX_Data_Valid;
                pa = Ack;
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"},   64'(Ack), 64'd0);
        chk({tag, "_data"},  64'(TX_Data), 64'd0);
        chk({tag, "_valid"}, 64'(TX_Data_Valid), 64'd0);
        chk({tag, "_gid"},   64'(Grant_Id), 64'd0);
        chk({tag, "_busy"},  64'(Busy), 64'd0);
        chk({tag, "_err"},   64'(Tx_Err), 64'd0);
    endtask

    // Stimulus
    initial begin
        int   win;
        exp_t e;
        m_pend   = '0;
        m_rr     = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) m_data[i] = '0;
        Rst_n    = 1'b0;
        TX_Ready = 1'b1;
        add_req('1);
        drive_req();
        repeat (3) tick();
        chk_outputs_zero("reset");

        // Release with everyone requesting: requester 0 first, then strict rotation
        Rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            add_req('1);
            do_transfer(0, n % 3, 2 + (n % 2), 1'b0);
        end
        while (m_pend != '0) do_transfer(0, 1, 1, 1'b0);

        // Lone requester 2 waiting on TX_Ready, then re-granted back-to-back
        add_req(4'b0100);
        do_transfer(9, 1, 2, 1'b0);
        add_req(4'b0100);
        do_transfer(0, 0, 1, 1'b0);

        // Requester 1 drops Req right after capture; transfer still completes
        add_req(4'b0010);
        m_data[1] = 55'h12345;
        do_transfer(0, 1, 3, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            logic [NUM_REQ-1:0] m;
            m = NUM_REQ'($urandom());
            add_req(m);
            if (m_pend == '0) add_req(NUM_REQ'(1) << $urandom_range(NUM_REQ - 1));
            do_transfer($urandom_range(3), $urandom_range(3), $urandom_range(5, 1),
                        ($urandom_range(3) == 0));
        end

        // Reset while in WAIT_DONE: outputs clear at once, no Ack is issued
        add_req(4'b0110);
        drive_req();
        TX_Ready = 1'b1;
        win    = pick(m_pend, m_rr);
        e.win  = win;
        e.data = m_data[win];
        e.vc   = 1;
        e.gap  = 0;
        grant_q.push_back(e);
        tick();
        TX_Ready = 1'b0;
        tick();
        tick();
        #2;
        Rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        TX_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_ack_in_reset", 64'(Ack), 64'd0);
        end
        m_rr = NUM_REQ - 1;
        add_req('1);
        Rst_n = 1'b1;
        do_transfer(0, 1, 2, 1'b0);
        while (m_pend != '0) do_transfer($urandom_range(2), 1, 2, 1'b0);

        repeat (4) tick();
        chk("scoreboard_drained", 64'(grant_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop if the run stalls
    initial begin
        #500000;
        $display("FAIL global_timeout: run still active at time %0t, expected completion earlier", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin scheduler that shares the single serial transmitter between NUM_REQ packet sources (input ports / token generator) of the router.
- Selects one pending requester, captures its 55-bit flit and drives the transmitter's TX_Data/TX_Data_Valid handshake.
- Tracks the transmitter's TX_Ready to detect acceptance and completion, then returns a one-cycle Ack to the winner.
- Sits between the router's switch/output queues and the transmitter, in the Clk_S domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 55, flit width; must match the transmitter's TX_Data.
- WD_LIMIT, 255, watchdog timeout in cycles (used only with TX_ARB_WATCHDOG_EN).

Ports:
- Clk_S  input  1  system clock; all logic on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  NUM_REQ  per-requester request; held high until its Ack.
- Req_Data  input  NUM_REQ*DATA_W  flits; requester i in bits [i*DATA_W +: DATA_W]; stable while Req[i]=1.
- Ack  output  NUM_REQ  one-hot, one-cycle pulse when the granted flit has been fully transmitted.
- TX_Data  output  DATA_W  flit to the transmitter (registered).
- TX_Data_Valid  output  1  start request to the transmitter (registered).
- TX_Ready  input  1  transmitter ready (registered on the transmitter side, lags its state by one cycle).
- Grant_Id  output  clog2(NUM_REQ)  index of the current/last winner.
- Busy  output  1  high in any state other than IDLE.
- Tx_Err  output  1  one-cycle watchdog abort pulse (constant 0 without the macro).

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; Ack=0, TX_Data=0, TX_Data_Valid=0, Grant_Id=0, Busy=0, Tx_Err=0; rr_ptr=NUM_REQ-1, so requester 0 wins first. Reset mid-transfer drops the transfer silently with no Ack.
- States: IDLE, SEND, WAIT_DONE.
- IDLE: on an edge with TX_Ready=1 and |Req=1:
  - winner = first i with Req[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register TX_Data=Req_Data[winner], Grant_Id=winner, rr_ptr=winner, TX_Data_Valid=1, go SEND.
  - Latency from Req with TX_Ready high to TX_Data_Valid: 1 cycle.
  - TX_Ready=0 or no Req: stay in IDLE.
- SEND: hold TX_Data_Valid=1 and TX_Data until TX_Ready is sampled 0. TX_Ready can remain 1 for one or more cycles after Valid rises; that must not be treated as completion. On TX_Ready=0: TX_Data_Valid=0 next cycle, go WAIT_DONE.
- WAIT_DONE: TX_Data held stable and TX_Data_Valid=0. The transmitter needs Valid low to re-arm. On TX_Ready sampled 1: Ack[Grant_Id]=1 for exactly one cycle, go IDLE.
- IDLE never arbitrates in the same cycle Ack is high, so the minimum gap between grants is 1 cycle.
- Req[i] dropping after capture does not abort the transfer; Ack is still issued. Req dropping before the IDLE sample means no grant.
- Simultaneous requests: strict rotation. With all requesters active the grant order is 0,1,2,3,0,…
- A single requester held high is re-granted back-to-back.
- Req_Data of non-granted requesters is ignored. TX_Data changes only on an IDLE→SEND transition.

Optional Feature:
- Macro: TX_ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to SEND or WAIT_DONE and increments each cycle in those states.
  - On reaching WD_LIMIT: TX_Data_Valid=0, Tx_Err pulses 1 cycle, no Ack, rr_ptr keeps the winner so the next grant rotates past it, go IDLE.
- Undefined: no counter; SEND/WAIT_DONE wait indefinitely; Tx_Err tied 0.

Test Plan:
- Reset with Req=4'b1111 and TX_Ready=1 → all outputs 0 during reset. First edge after release: Grant_Id=0, TX_Data=Req_Data[0], TX_Data_Valid=1.
- Transmitter model: TX_Ready low 2 cycles after Valid, high 60 cycles later. Req=4'b1111 for 8 transfers → Ack order 0,1,2,3,0,1,2,3; each Ack a single cycle; Valid never high while TX_Ready=0 in WAIT_DONE.
- Req=4'b0100 only, TX_Ready=0 until cycle 10 → no Valid before cycle 11; Grant_Id=2; Ack[2] after completion; then re-grant to 2 if still requesting.
- Req[1] with data 55'h12345 dropped the cycle after grant → transfer completes, TX_Data stays 55'h12345 through WAIT_DONE, Ack[1] pulses.
- Rst_n asserted during WAIT_DONE → outputs 0 immediately, no Ack; after release requester 0 wins first.
- With TX_ARB_WATCHDOG_EN and WD_LIMIT=16, TX_Ready stuck 1 after Valid → Tx_Err pulse at cycle 16, Valid=0, no Ack. Next grant goes to the next pending index.
